pimp_core: RTL and testbench
============================

# pimp_core

Parametrised second-generation PIMP processor core: a 9-bit-instruction, 8-register accumulator-style machine with configurable data and PC widths. It adds a run-control state machine (IDLE/RUN/LOAD_WAIT/HALTED), a HALT instruction with a `Done` flag, a two-cycle load against synchronous data memory, restart-while-running, and a saturating retired-instruction counter. It sits between the external instruction ROM and data RAM and is the core instantiated by the system top level.

## Interface
- `DATA_W`, default 8: register, ALU and data-memory word width (≥ 8).
- `PC_W`, default 8: program counter and instruction address width.
- `DMEM_AW`, default 8: data-memory address width; address is the low `DMEM_AW` bits of r6.
- `COUNT_W`, default 16: `InstrCount` width.
- `CLK` in 1: the single clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `Start` in 1: restart request; level sampled each cycle.
- `Start_Addr` in `PC_W`: PC loaded on `Start`.
- `Imem_Addr` out `PC_W`: equals PC.
- `Imem_Data` in 9: instruction at `Imem_Addr`; combinational ROM.
- `Dmem_Addr` out `DMEM_AW`: r6[DMEM_AW-1:0].
- `Dmem_Rd_En` out 1: read request; data is returned the next cycle.
- `Dmem_Rd_Data` in `DATA_W`: read data, one cycle after `Dmem_Rd_En`.
- `Dmem_Wr_En` out 1: write strobe; the write is committed at the clock edge.
- `Dmem_Wr_Data` out `DATA_W`: register rs.
- `Done` out 1: core halted.
- `InstrCount` out `COUNT_W`: retired instructions since the last `Start`.

## Operation
Instruction fields: op = [8:6], rs = [5:3], rt = [2:0].
- 000 ADD: rs ← rs + rt.
- 001 SUB: rs ← rs − rt.
- 010 AND: rs ← rs & rt.
- 011 CPY: rs ← rt.
- 100 SH: rs ← rs shifted by (rt[1:0] + 1). Direction is left if rt[2]=0, logical right if rt[2]=1.
- 101 LD: rs ← mem[r6].
- 110 ST: mem[r6] ← rs.
- 111 BEQ: if r0 == r1, PC ← PC + sext([5:0]); otherwise PC + 1. The encoding 111_000000 is HALT.

Arithmetic is modulo 2^DATA_W with no flags. The PC wraps modulo 2^PC_W. All 8 registers are writable. Registers are not cleared by `Start`.

FSM:
- **IDLE**: no memory strobes. `Start` → RUN.
- **RUN**: decode and execute `Imem_Data` each cycle.
  - Non-LD, non-HALT instructions retire in one cycle; go to PC+1 or the branch target.
  - LD asserts `Dmem_Rd_En` and goes to LOAD_WAIT; PC is held.
  - HALT goes to HALTED; PC is held and the instruction is not counted.
- **LOAD_WAIT**: write `Dmem_Rd_Data` to rs, then PC+1, then RUN. The load retires here.
- **HALTED**: `Done`=1. `Start` → RUN.

`Start` has priority over everything except reset, in every state:
- PC ← `Start_Addr`, `InstrCount` ← 0, `Done` ← 0, next state RUN.
- An in-flight LOAD_WAIT write-back is discarded.
- The current RUN instruction does not write or retire; `Dmem_Wr_En` is forced to 0 that cycle.

## Timing
- Reset values: PC=0, state IDLE, regs=0, `Done`=0, `InstrCount`=0, `Dmem_Rd_En`=`Dmem_Wr_En`=0.
- `Imem_Addr`, `Dmem_*` are combinational from state, PC, instruction and registers. `Done` and `InstrCount` are registered.
- Start at edge n: PC=`Start_Addr` and RUN from cycle n+1.
- Instruction latency:
  - Non-load instructions: 1 cycle.
  - LD: 2 cycles.
  - HALT: `Done`=1 from the cycle after HALT is decoded.
- `InstrCount` increments on each retire edge and saturates at all-ones.
- ST followed by LD to the same address returns the new value; RAM write-before-read ordering is guaranteed by the one-cycle spacing.
- `Reset_n`=0 in any state, including LOAD_WAIT, returns to reset values at the next edge.

## Configuration
- `PIMP_ICOUNT_EN` defined: counter as specified above.
- Macro undefined: counter logic is omitted and `InstrCount` is tied to 0.
- Either way, HALT behaviour and `Done` are unchanged.

## Structure
- `pimp_pkg` contents:
  - `opcode_t` enum (ADD…BEQ).
  - `state_t` enum (IDLE, RUN, LOAD_WAIT, HALTED).
  - `INSTR_W`=9 and `HALT_INSTR`=9'b111_000000.
  - `NREGS`=8 and the r0/r1/r6 index constants.
- Sub-module `pimp_regfile`:
  - Parameter `DATA_W`.
  - Two read ports (rs, rt) plus fixed r0/r1/r6 taps.
  - One synchronous write port.
- ALU, shifter and FSM live in `pimp_core`.

## Test plan
- **Restart and initial load.** Reset, then `Start`=1 for one cycle with `Start_Addr`=8'h10. Required: `Imem_Addr`=8'h10 the next cycle and `Done`=0. With dmem[0]=8'h07, LD r2 gives r2=8'h07 after 2 cycles and `InstrCount`=1.
- **ALU sequence.** LD r2 ← 7 and LD r3 ← 5 (via r6=0 and r6 updated through CPY), then ADD r2,r3 → 8'h0C, SUB r3,r2 → 8'hF9, SH r2 with rt=3'b101 → 8'h03. Required: ST writes 8'h03 to `Dmem_Addr`=r6.
- **Branch and HALT.** With r0==r1, BEQ offset 6'b111110 at PC=0x14 goes to PC=0x12. HALT at 0x15 gives `Done`=1 the next cycle, PC held, and `InstrCount` excludes the HALT.
- **Start during LOAD_WAIT.** Assert `Start` in the LOAD_WAIT cycle. Required: the target register is unchanged, PC=`Start_Addr`, and `InstrCount`=0.
- **Width variant.** With DATA_W=16 and PC_W=10, SUB 0−1 gives 16'hFFFF. A PC at 10'h3FF wraps to 10'h000 on retire.
- **Counter saturation.** With COUNT_W=4 and `PIMP_ICOUNT_EN` defined, a 20-instruction loop gives `InstrCount`=4'hF. With the macro undefined, `InstrCount` stays 0.

Source files
------------

// File: rtl/pimp_pkg.sv
// Shared types and constants for the PIMP core: opcodes, run-control states,
// instruction format constants and fixed register indices.
package pimp_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b111_000000;

  localparam int unsigned NREGS = 8;
  localparam logic [2:0] R0_IDX = 3'd0;
  localparam logic [2:0] R1_IDX = 3'd1;
  localparam logic [2:0] R6_IDX = 3'd6;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpCpy = 3'b011,
    OpSh  = 3'b100,
    OpLd  = 3'b101,
    OpSt  = 3'b110,
    OpBeq = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLoadWait,
    StHalted
  } state_t;

  // Ops whose result lands in rs in the same cycle they execute.
  function automatic logic is_alu_op(opcode_t op);
    return op inside {OpAdd, OpSub, OpAnd, OpCpy, OpSh};
  endfunction

endpackage

// File: rtl/pimp_regfile.sv
// Eight-entry register file: rs/rt read ports, fixed r0/r1/r6 taps and one
// synchronous write port. Synchronous active-low reset clears every entry.
module pimp_regfile
  import pimp_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        rs_addr,
  input  logic [2:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] r0_data,
  output logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] r6_data,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];
  assign r0_data = regs[R0_IDX];
  assign r1_data = regs[R1_IDX];
  assign r6_data = regs[R6_IDX];

endmodule

// File: rtl/pimp_core.sv
// PIMP accumulator core with IDLE/RUN/LOAD_WAIT/HALTED run control and HALT.
// Define PIMP_ICOUNT_EN to build the saturating retired-instruction counter.
module pimp_core
  import pimp_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DMEM_AW = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [PC_W-1:0]    Start_Addr,
  output logic [PC_W-1:0]    Imem_Addr,
  input  logic [INSTR_W-1:0] Imem_Data,
  output logic [DMEM_AW-1:0] Dmem_Addr,
  output logic               Dmem_Rd_En,
  input  logic [DATA_W-1:0]  Dmem_Rd_Data,
  output logic               Dmem_Wr_En,
  output logic [DATA_W-1:0]  Dmem_Wr_Data,
  output logic               Done,
  output logic [COUNT_W-1:0] InstrCount
);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic            done_q;
  logic [2:0]      ld_rs_q;

  opcode_t    op;
  logic [2:0] rs_idx;
  logic [2:0] rt_idx;
  logic       is_halt;
  logic       run;

  assign op      = opcode_t'(Imem_Data[8:6]);
  assign rs_idx  = Imem_Data[5:3];
  assign rt_idx  = Imem_Data[2:0];
  assign is_halt = (Imem_Data == HALT_INSTR);
  assign run     = (state_q == StRun);

  logic [DATA_W-1:0] rs_data, rt_data, r0_data, r1_data, r6_data;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu;
  logic [2:0]        shamt;
  logic [PC_W-1:0]   br_off;

  pimp_regfile #(
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk    (CLK),
    .reset_n(Reset_n),
    .rs_addr(rs_idx),
    .rt_addr(rt_idx),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .r0_data(r0_data),
    .r1_data(r1_data),
    .r6_data(r6_data),
    .wr_en  (rf_we),
    .wr_addr(rf_waddr),
    .wr_data(rf_wdata)
  );

  // Shift distance is 1..4; rt[2] of the field selects logical right.
  assign shamt  = {1'b0, rt_idx[1:0]} + 3'd1;
  assign br_off = PC_W'($signed(Imem_Data[5:0]));

  always_comb begin
    alu = rs_data;
    case (op)
      OpAdd:   alu = rs_data + rt_data;
      OpSub:   alu = rs_data - rt_data;
      OpAnd:   alu = rs_data & rt_data;
      OpCpy:   alu = rt_data;
      OpSh:    alu = rt_idx[2] ? (rs_data >> shamt) : (rs_data << shamt);
      default: alu = rs_data;
    endcase
  end

  // Start suppresses both the RUN write-back and an in-flight load.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rs_idx;
    rf_wdata = alu;
    if (!Start) begin
      if (run && is_alu_op(op)) begin
        rf_we = 1'b1;
      end else if (state_q == StLoadWait) begin
        rf_we    = 1'b1;
        rf_waddr = ld_rs_q;
        rf_wdata = Dmem_Rd_Data;
      end
    end
  end

  assign Imem_Addr    = pc_q;
  assign Dmem_Addr    = r6_data[DMEM_AW-1:0];
  assign Dmem_Rd_En   = run && (op == OpLd);
  assign Dmem_Wr_En   = run && (op == OpSt) && !Start;
  assign Dmem_Wr_Data = rs_data;
  assign Done         = done_q;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      done_q  <= 1'b0;
      ld_rs_q <= '0;
    end else if (Start) begin
      state_q <= StRun;
      pc_q    <= Start_Addr;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StRun: begin
          if (is_halt) begin
            state_q <= StHalted;
            done_q  <= 1'b1;
          end else if (op == OpLd) begin
            state_q <= StLoadWait;
            ld_rs_q <= rs_idx;
          end else if ((op == OpBeq) && (r0_data == r1_data)) begin
            pc_q <= pc_q + br_off;
          end else begin
            pc_q <= pc_q + PC_W'(1);
          end
        end
        StLoadWait: begin
          state_q <= StRun;
          pc_q    <= pc_q + PC_W'(1);
        end
        StHalted: ;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PIMP_ICOUNT_EN
  logic               retire;
  logic [COUNT_W-1:0] icount_q;

  assign retire = !Start &&
                  ((run && !is_halt && (op != OpLd)) || (state_q == StLoadWait));

  always_ff @(posedge CLK) begin
    if (!Reset_n || Start) begin
      icount_q <= '0;
    end else if (retire && (icount_q != '1)) begin
      icount_q <= icount_q + COUNT_W'(1);
    end
  end

  assign InstrCount = icount_q;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_pimp_core.sv
// Scoreboard bench for pimp_core: stores are checked against a queue of
// expected (address, data) pairs; control outputs are checked at fixed cycles.
module tb_pimp_core;

`ifdef PIMP_ICOUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } st_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A: default widths.
  logic        start_a;
  logic [7:0]  start_addr_a, imem_addr_a, dmem_addr_a, rd_data_a, wr_data_a;
  logic [8:0]  imem_data_a;
  logic        rd_en_a, wr_en_a, done_a;
  logic [15:0] count_a;
  logic [8:0]  rom_a [256];
  logic [7:0]  ram_a [256];

  // Instance B: wide data, 10-bit PC, 4-bit counter.
  logic        start_b;
  logic [9:0]  start_addr_b, imem_addr_b;
  logic [7:0]  dmem_addr_b;
  logic [15:0] rd_data_b, wr_data_b;
  logic [8:0]  imem_data_b;
  logic        rd_en_b, wr_en_b, done_b;
  logic [3:0]  count_b;
  logic [8:0]  rom_b [1024];
  logic [15:0] ram_b [256];

  pimp_core u_dut_a (
    .CLK         (clk),
    .Reset_n     (reset_n),
    .Start       (start_a),
    .Start_Addr  (start_addr_a),
    .Imem_Addr   (imem_addr_a),
    .Imem_Data   (imem_data_a),
    .Dmem_Addr   (dmem_addr_a),
    .Dmem_Rd_En  (rd_en_a),
    .Dmem_Rd_Data(rd_data_a),
    .Dmem_Wr_En  (wr_en_a),
    .Dmem_Wr_Data(wr_data_a),
    .Done        (done_a),
    .InstrCount  (count_a)
  );

  pimp_core #(
    .DATA_W (16),
    .PC_W   (10),
    .DMEM_AW(8),
    .COUNT_W(4)
  ) u_dut_b (
    .CLK         (clk),
    .Reset_n     (reset_n),
    .Start       (start_b),
    .Start_Addr  (start_addr_b),
    .Imem_Addr   (imem_addr_b),
    .Imem_Data   (imem_data_b),
    .Dmem_Addr   (dmem_addr_b),
    .Dmem_Rd_En  (rd_en_b),
    .Dmem_Rd_Data(rd_data_b),
    .Dmem_Wr_En  (wr_en_b),
    .Dmem_Wr_Data(wr_data_b),
    .Done        (done_b),
    .InstrCount  (count_b)
  );

  assign imem_data_a = rom_a[imem_addr_a];
  assign imem_data_b = rom_b[imem_addr_b];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) ram_a[i] <= 8'h00;
      ram_a[0] <= 8'h07;
      ram_a[7] <= 8'h05;
      rd_data_a <= 8'h00;
    end else begin
      if (rd_en_a) rd_data_a <= ram_a[dmem_addr_a];
      if (wr_en_a) ram_a[dmem_addr_a] <= wr_data_a;
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) ram_b[i] <= 16'h0000;
      ram_b[0] <= 16'h0001;
      rd_data_b <= 16'h0000;
    end else begin
      if (rd_en_b) rd_data_b <= ram_b[dmem_addr_b];
      if (wr_en_b) ram_b[dmem_addr_b] <= wr_data_b;
    end
  end

  int  checks = 0;
  int  fails  = 0;
  st_t exp_a[$];
  st_t exp_b[$];
  st_t got_a, got_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n, input int w);
    int sat;
    sat = (1 << w) - 1;
    return CountEn ? 32'((n > sat) ? sat : n) : 32'd0;
  endfunction

  always @(negedge clk) begin
    if (reset_n && wr_en_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL store_a unexpected: addr %0h data %0h, none required",
                 dmem_addr_a, wr_data_a);
      end else begin
        got_a = exp_a.pop_front();
        check("store_a_addr", 32'(dmem_addr_a), 32'(got_a.addr));
        check("store_a_data", 32'(wr_data_a), 32'(got_a.data));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && wr_en_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL store_b unexpected: addr %0h data %0h, none required",
                 dmem_addr_b, wr_data_b);
      end else begin
        got_b = exp_b.pop_front();
        check("store_b_addr", 32'(dmem_addr_b), 32'(got_b.addr));
        check("store_b_data", 32'(wr_data_b), 32'(got_b.data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse_a(input logic [7:0] addr);
    start_a      = 1'b1;
    start_addr_a = addr;
    step(1);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int limit);
    for (int i = 0; i < limit && !done_a; i++) step(1);
    check("done_a_reached", 32'(done_a), 32'd1);
  endtask

  task automatic wait_done_b(input int limit);
    for (int i = 0; i < limit && !done_b; i++) step(1);
    check("done_b_reached", 32'(done_b), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_a[i] = 9'b111_000000;
    for (int i = 0; i < 1024; i++) rom_b[i] = 9'b111_000000;
    rom_a[8'h00] = 9'b110_000_000;  // ST r0: must stay idle
    rom_a[8'h10] = 9'b101_010_000;  // LD r2
    rom_a[8'h11] = 9'b111_001111;   // BEQ +15 -> 0x20
    rom_a[8'h12] = 9'b011_000_010;  // CPY r0,r2
    rom_a[8'h13] = 9'b110_000_000;  // ST r0
    rom_a[8'h14] = 9'b111_111110;   // BEQ -2
    rom_a[8'h20] = 9'b011_110_010;  // CPY r6,r2
    rom_a[8'h21] = 9'b101_011_000;  // LD r3
    rom_a[8'h22] = 9'b000_010_011;  // ADD r2,r3
    rom_a[8'h23] = 9'b110_010_000;  // ST r2
    rom_a[8'h24] = 9'b001_011_010;  // SUB r3,r2
    rom_a[8'h25] = 9'b110_011_000;  // ST r3
    rom_a[8'h26] = 9'b100_010_101;  // SH r2 right by 2
    rom_a[8'h27] = 9'b110_010_000;  // ST r2
    rom_a[8'h28] = 9'b101_100_000;  // LD r4
    rom_a[8'h29] = 9'b110_100_000;  // ST r4
    rom_a[8'h30] = 9'b101_101_000;  // LD r5
    rom_a[8'h38] = 9'b110_101_000;  // ST r5
    rom_b[10'h3FC] = 9'b101_001_000;  // LD r1
    rom_b[10'h3FD] = 9'b001_010_001;  // SUB r2,r1
    rom_b[10'h3FE] = 9'b110_010_000;  // ST r2
    rom_b[10'h3FF] = 9'b011_011_011;  // CPY r3,r3
    for (int i = 0; i < 16; i++) rom_b[i] = 9'b011_101_101;

    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_addr_a = 8'h00;
    start_addr_b = 10'h000;
    step(3);
    check("reset_pc", 32'(imem_addr_a), 32'h0);
    check("reset_done", 32'(done_a), 32'h0);
    check("reset_count", 32'(count_a), 32'h0);
    check("reset_rd_en", 32'(rd_en_a), 32'h0);
    check("reset_wr_en", 32'(wr_en_a), 32'h0);
    reset_n = 1'b1;
    step(2);
    check("idle_pc", 32'(imem_addr_a), 32'h0);
    check("idle_wr_en", 32'(wr_en_a), 32'h0);

    // Restart, initial load and ALU sequence.
    exp_a.push_back('{8'h07, 16'h000C});
    exp_a.push_back('{8'h07, 16'h00F9});
    exp_a.push_back('{8'h07, 16'h0003});
    exp_a.push_back('{8'h07, 16'h0003});
    start_pulse_a(8'h10);
    check("start_pc", 32'(imem_addr_a), 32'h10);
    check("start_done", 32'(done_a), 32'h0);
    check("ld_rd_en", 32'(rd_en_a), 32'h1);
    step(2);
    check("ld_retire_count", 32'(count_a), exp_cnt(1, 16));
    check("ld_retire_pc", 32'(imem_addr_a), 32'h11);
    wait_done_a(40);
    check("alu_halt_pc", 32'(imem_addr_a), 32'h2A);
    check("alu_halt_count", 32'(count_a), exp_cnt(12, 16));
    step(1);
    check("alu_halt_pc_held", 32'(imem_addr_a), 32'h2A);

    // Branch back, fall-through and HALT.
    exp_a.push_back('{8'h07, 16'h0003});
    start_pulse_a(8'h14);
    check("br_start_pc", 32'(imem_addr_a), 32'h14);
    step(1);
    check("br_taken_pc", 32'(imem_addr_a), 32'h12);
    step(2);
    check("br_loop_pc", 32'(imem_addr_a), 32'h14);
    step(1);
    check("br_not_taken_pc", 32'(imem_addr_a), 32'h15);
    check("halt_decode_done", 32'(done_a), 32'h0);
    step(1);
    check("halt_done", 32'(done_a), 32'h1);
    check("halt_pc_held", 32'(imem_addr_a), 32'h15);
    check("halt_count", 32'(count_a), exp_cnt(4, 16));

    // Start during LOAD_WAIT discards the load.
    exp_a.push_back('{8'h07, 16'h0000});
    start_pulse_a(8'h30);
    step(1);
    check("lw_pc_held", 32'(imem_addr_a), 32'h30);
    start_pulse_a(8'h38);
    check("lw_restart_pc", 32'(imem_addr_a), 32'h38);
    check("lw_restart_count", 32'(count_a), 32'h0);
    check("lw_restart_done", 32'(done_a), 32'h0);
    step(2);
    check("lw_done", 32'(done_a), 32'h1);
    check("lw_count", 32'(count_a), exp_cnt(1, 16));

    // Start held over a ST cycle: that store must not happen.
    exp_a.push_back('{8'h07, 16'h0000});
    start_a = 1'b1;
    start_addr_a = 8'h38;
    step(2);
    start_a = 1'b0;
    check("st_suppress_pc", 32'(imem_addr_a), 32'h38);
    step(2);
    check("st_suppress_done", 32'(done_a), 32'h1);
    check("st_suppress_count", 32'(count_a), exp_cnt(1, 16));

    // Reset in LOAD_WAIT.
    start_pulse_a(8'h30);
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("lw_reset_pc", 32'(imem_addr_a), 32'h0);
    check("lw_reset_rd_en", 32'(rd_en_a), 32'h0);
    check("lw_reset_done", 32'(done_a), 32'h0);

    // Wide variant: 0 - 1, PC wrap and counter saturation.
    exp_b.push_back('{8'h00, 16'hFFFF});
    start_b = 1'b1;
    start_addr_b = 10'h3FC;
    step(1);
    start_b = 1'b0;
    check("b_start_pc", 32'(imem_addr_b), 32'h3FC);
    step(5);
    check("b_pc_wrap", 32'(imem_addr_b), 32'h000);
    wait_done_b(40);
    check("b_halt_pc", 32'(imem_addr_b), 32'h010);
    check("b_count_sat", 32'(count_b), exp_cnt(20, 4));

    step(2);
    check("a_stores_drained", 32'(exp_a.size()), 32'd0);
    check("b_stores_drained", 32'(exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
